// File: rtl/sm_pipe_pkg.sv
// Shared helpers for the sm_pipe_reg elastic pipeline register.
// The optional data clear (SM_PIPE_REG_DATA_RESET_EN) lives in sm_pipe_stage.
package sm_pipe_pkg;

   // Width of an occupancy counter that must reach DEPTH.
   function automatic int cnt_width(input int depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sm_pipe_stage.sv
// One slot of the elastic pipeline: valid bit plus data word.
// Build option SM_PIPE_REG_DATA_RESET_EN also clears the data on reset/flush.
module sm_pipe_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             load,
   input  logic             vin,
   input  logic [WIDTH-1:0] din,
   output logic             vout,
   output logic [WIDTH-1:0] dout
);

   always_ff @(posedge clk) begin
      if (!rst || flush)
         vout <= 1'b0;
      else if (load)
         vout <= vin;
   end

`ifdef SM_PIPE_REG_DATA_RESET_EN
   always_ff @(posedge clk) begin
      if (!rst || flush)
         dout <= '0;
      else if (load && vin)
         dout <= din;
   end
`else
   // A bubble moving forward leaves the old word in place.
   always_ff @(posedge clk) begin
      if (load && vin)
         dout <= din;
   end
`endif

endmodule

// File: rtl/sm_pipe_reg.sv
// Elastic DEPTH-stage pipeline register with valid/ready on both sides.
// Optional data clear on reset/flush: define SM_PIPE_REG_DATA_RESET_EN.
module sm_pipe_reg
   import sm_pipe_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CNT_W = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] count
);

   logic [DEPTH-1:0]            v;
   logic [DEPTH-1:0]            rdy;
   logic [DEPTH-1:0]            vin;
   logic [DEPTH-1:0][WIDTH-1:0] din;
   logic [DEPTH-1:0][WIDTH-1:0] d;
   logic                        in_xfer;
   logic                        out_xfer;

   // A stage may load if it is empty or everything ahead of it moves;
   // this makes out_ready -> in_ready a deliberate combinational path.
   always_comb begin
      rdy            = '0;
      rdy[DEPTH-1]   = out_ready | ~v[DEPTH-1];
      for (int i = DEPTH - 2; i >= 0; i--)
         rdy[i] = rdy[i+1] | ~v[i];
   end

   assign in_ready  = rdy[0] & ~flush;
   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign vin[i] = in_valid & ~flush;
         assign din[i] = in_data;
      end else begin : g_body
         assign vin[i] = v[i-1];
         assign din[i] = d[i-1];
      end

      sm_pipe_stage #(.WIDTH(WIDTH)) u_stage (
         .clk   (clk),
         .rst   (rst),
         .flush (flush),
         .load  (rdy[i]),
         .vin   (vin[i]),
         .din   (din[i]),
         .vout  (v[i]),
         .dout  (d[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst || flush)
         count <= '0;
      else if (in_xfer && !out_xfer)
         count <= count + CNT_W'(1);
      else if (!in_xfer && out_xfer)
         count <= count - CNT_W'(1);
   end

endmodule

// File: tb/tb_sm_pipe_reg.sv
// Directed bench for sm_pipe_reg: DEPTH 2/3/4 instances share one stimulus.
// Honours SM_PIPE_REG_DATA_RESET_EN for the data-clear checks.
module tb_sm_pipe_reg;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_ready;

   logic        ir2, ov2, ir3, ov3, ir4, ov4;
   logic [31:0] od2, od3, od4;
   logic [1:0]  cnt2;
   logic [1:0]  cnt3;
   logic [2:0]  cnt4;

   int n_tests = 0;
   int n_fail  = 0;

   sm_pipe_reg #(.WIDTH(32), .DEPTH(2)) dut2 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2),
      .in_data(in_data), .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .count(cnt2));
   sm_pipe_reg #(.WIDTH(32), .DEPTH(3)) dut3 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
      .in_data(in_data), .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .count(cnt3));
   sm_pipe_reg #(.WIDTH(32), .DEPTH(4)) dut4 (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir4),
      .in_data(in_data), .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .count(cnt4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        r, f, iv;
      logic [31:0] di;
      logic        o;
      logic        ck, e_ir, e_ov;
      logic [31:0] e_od;
      logic [1:0]  e_cnt;
      logic        cz;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, f, iv, input logic [31:0] di, input logic o,
                               input logic ck, e_ir, e_ov, input logic [31:0] e_od,
                               input logic [1:0] e_cnt, input logic cz);
      vec_t t;
      t.r = r; t.f = f; t.iv = iv; t.di = di; t.o = o;
      t.ck = ck; t.e_ir = e_ir; t.e_ov = e_ov; t.e_od = e_od; t.e_cnt = e_cnt; t.cz = cz;
      return t;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Inputs change on the falling edge; outputs are sampled 1ns later.
   task automatic drive(input logic r, f, iv, input logic [31:0] dd, input logic o);
      @(negedge clk);
      rst = r; flush = f; in_valid = iv; in_data = dd; out_ready = o;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   logic [31:0] s_in  [7];
   logic [31:0] s_od  [7];
   logic        s_ov  [7];
   int          s_cnt [7];
   logic        b_ov  [6];
   logic        b_ir  [6];
   int          b_cnt [6];

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

      // DEPTH=2: reset, back-pressure fill, pass-through, flush, reset priority
      //                 r  f  iv di      o  ck ir ov od      cnt cz
      tbl.push_back(mk(0, 0, 1, 32'hAA, 0, 0, 0, 0, 32'h0,  0, 0));
      tbl.push_back(mk(0, 0, 1, 32'hAA, 0, 1, 1, 0, 32'h0,  0, 0));
      tbl.push_back(mk(1, 0, 1, 32'hA,  0, 1, 1, 0, 32'h0,  0, 1));
      tbl.push_back(mk(1, 0, 1, 32'hB,  0, 1, 1, 0, 32'h0,  1, 0));
      tbl.push_back(mk(1, 0, 1, 32'hC,  0, 1, 0, 1, 32'hA,  2, 0));
      tbl.push_back(mk(1, 0, 1, 32'hC,  0, 1, 0, 1, 32'hA,  2, 0));
      tbl.push_back(mk(1, 0, 1, 32'hC,  1, 1, 1, 1, 32'hA,  2, 0));
      tbl.push_back(mk(1, 0, 0, 32'h0,  1, 1, 1, 1, 32'hB,  2, 0));
      tbl.push_back(mk(1, 0, 0, 32'h0,  1, 1, 1, 1, 32'hC,  1, 0));
      tbl.push_back(mk(1, 0, 0, 32'h0,  1, 1, 1, 0, 32'h0,  0, 0));
      tbl.push_back(mk(1, 0, 1, 32'h10, 0, 1, 1, 0, 32'h0,  0, 0));
      tbl.push_back(mk(1, 0, 1, 32'h20, 0, 1, 1, 0, 32'h0,  1, 0));
      tbl.push_back(mk(1, 0, 1, 32'h30, 1, 1, 1, 1, 32'h10, 2, 0));
      tbl.push_back(mk(1, 0, 1, 32'h40, 1, 1, 1, 1, 32'h20, 2, 0));
      tbl.push_back(mk(1, 0, 1, 32'h50, 1, 1, 1, 1, 32'h30, 2, 0));
      tbl.push_back(mk(1, 0, 1, 32'h60, 1, 1, 1, 1, 32'h40, 2, 0));
      tbl.push_back(mk(1, 0, 0, 32'h0,  0, 1, 0, 1, 32'h50, 2, 0));
      tbl.push_back(mk(1, 1, 1, 32'h77, 1, 1, 0, 1, 32'h50, 2, 0));
      tbl.push_back(mk(1, 0, 0, 32'h0,  0, 1, 1, 0, 32'h0,  0, 1));
      tbl.push_back(mk(0, 1, 1, 32'h99, 1, 1, 0, 0, 32'h0,  0, 0));
      tbl.push_back(mk(1, 0, 0, 32'h0,  0, 1, 1, 0, 32'h0,  0, 1));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].di, tbl[i].o);
         if (tbl[i].ck) begin
            chk($sformatf("d2.v%0d.in_ready", i),  32'(ir2),  32'(tbl[i].e_ir));
            chk($sformatf("d2.v%0d.out_valid", i), 32'(ov2),  32'(tbl[i].e_ov));
            chk($sformatf("d2.v%0d.count", i),     32'(cnt2), 32'(tbl[i].e_cnt));
            if (tbl[i].e_ov)
               chk($sformatf("d2.v%0d.out_data", i), od2, tbl[i].e_od);
`ifdef SM_PIPE_REG_DATA_RESET_EN
            if (tbl[i].cz)
               chk($sformatf("d2.v%0d.data_clear", i), od2, 32'h0);
`endif
         end
      end

      // DEPTH=3 streaming: output appears 3 cycles after acceptance
      s_in  = '{32'h11, 32'h22, 32'h33, 0, 0, 0, 0};
      s_ov  = '{0, 0, 0, 1, 1, 1, 0};
      s_od  = '{0, 0, 0, 32'h11, 32'h22, 32'h33, 0};
      s_cnt = '{0, 1, 2, 3, 2, 1, 0};
      drive(0, 0, 0, 0, 1);
      for (int k = 0; k < 7; k++) begin
         drive(1, 0, (k < 3), s_in[k], 1);
         chk($sformatf("d3.stream%0d.out_valid", k), 32'(ov3), 32'(s_ov[k]));
         chk($sformatf("d3.stream%0d.count", k),     32'(cnt3), 32'(s_cnt[k]));
         chk($sformatf("d3.stream%0d.in_ready", k),  32'(ir3), 32'h1);
         if (s_ov[k])
            chk($sformatf("d3.stream%0d.out_data", k), od3, s_od[k]);
      end

      // DEPTH=3 bubble collapse: lone entry walks to the end under stall
      s_in  = '{32'h5, 0, 0, 32'h6, 32'h7, 0, 0};
      b_ov  = '{0, 0, 0, 1, 1, 1};
      b_ir  = '{1, 1, 1, 1, 1, 0};
      b_cnt = '{0, 1, 1, 1, 2, 3};
      drive(0, 0, 0, 0, 0);
      for (int k = 0; k < 6; k++) begin
         drive(1, 0, (k == 0 || k == 3 || k == 4), s_in[k], 0);
         chk($sformatf("d3.bubble%0d.out_valid", k), 32'(ov3), 32'(b_ov[k]));
         chk($sformatf("d3.bubble%0d.in_ready", k),  32'(ir3), 32'(b_ir[k]));
         chk($sformatf("d3.bubble%0d.count", k),     32'(cnt3), 32'(b_cnt[k]));
         if (b_ov[k])
            chk($sformatf("d3.bubble%0d.out_data", k), od3, 32'h5);
      end

      // DEPTH=4 flush with 3 held entries, input offered during flush
      drive(0, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++)
         drive(1, 0, 1, 32'(k + 1), 0);
      drive(1, 1, 1, 32'hEE, 0);
      chk("d4.pre_flush.count",    32'(cnt4), 32'd3);
      chk("d4.pre_flush.in_ready", 32'(ir4),  32'd0);
      drive(1, 0, 0, 0, 0);
      chk("d4.post_flush.count",     32'(cnt4), 32'd0);
      chk("d4.post_flush.out_valid", 32'(ov4),  32'd0);
      chk("d4.post_flush.in_ready",  32'(ir4),  32'd1);

      // reset wins over flush with entries held
      drive(1, 0, 1, 32'h21, 0);
      drive(1, 0, 1, 32'h22, 0);
      drive(0, 1, 1, 32'hFF, 1);
      chk("d4.pre_rst.count", 32'(cnt4), 32'd2);
      drive(1, 0, 0, 0, 0);
      chk("d4.post_rst.count",     32'(cnt4), 32'd0);
      chk("d4.post_rst.out_valid", 32'(ov4),  32'd0);
      chk("d4.post_rst.in_ready",  32'(ir4),  32'd1);
`ifdef SM_PIPE_REG_DATA_RESET_EN
      chk("d4.post_rst.data_clear", od4, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sm_pipe_reg.md
Name: sm_pipe_reg

Overview:
Parametrised elastic pipeline register, the successor to the plain and write-enable registers. It holds DEPTH stages of WIDTH-bit data with per-stage valid bits and a valid/ready handshake on both sides. Empty stages collapse, so a downstream stall ripples back only as far as the first bubble. It sits between schoolMIPS pipeline stages and between the core and memory-mapped peripherals where back-pressure is needed.

Parameters:
WIDTH, 32, data width in bits (>=1)
DEPTH, 2, number of register stages (>=1)
CNT_W, $clog2(DEPTH+1), width of occupancy count (derived; do not override)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-low; clears state on the clk edge where rst==0
flush  input  1  synchronous flush; discards all held entries
in_valid  input  1  upstream presents in_data
in_ready  output  1  block accepts in_data this cycle
in_data  input  WIDTH  upstream data
out_valid  output  1  last stage holds an entry
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  last-stage data
count  output  CNT_W  number of valid stages, 0..DEPTH

Behaviour:
- Stage index 0 is the input side and DEPTH-1 is the output side. Each stage holds v[i] and d[i].
- Ready chain (combinational):
  - rdy[DEPTH-1] = out_ready | ~v[DEPTH-1]
  - rdy[i] = rdy[i+1] | ~v[i]
  - in_ready = rdy[0] & ~flush
- Combinational path out_ready -> in_ready is intentional and documented.
- Stage i loads when rdy[i]==1:
  - Stage 0: v[0] <= in_valid & ~flush, d[0] <= in_data.
  - Stage i>0: v[i] <= v[i-1], d[i] <= d[i-1].
- Stage i holds v[i] and d[i] when rdy[i]==0.
- d[i] is written only when the incoming valid is 1; a bubble moving forward leaves d unchanged.
- Transfers: an input transfer is in_valid & in_ready; an output transfer is out_valid & out_ready. The DEPTH==1 case uses the same equations.
- Latency: with out_ready held at 1, data accepted on edge N appears on out_data/out_valid after edge N+DEPTH-1, i.e. DEPTH cycles from in_valid to out_valid. Throughput is 1 per cycle.
- Full (all v=1, out_ready=0): in_ready=0, all state held.
- Full with out_ready=1: simultaneous input and output transfer in one cycle, and count is unchanged.
- Empty: out_valid=0 and count=0. out_data is don't-care.
- count is registered and updated every edge:
  - +1 on input transfer only
  - -1 on output transfer only
  - unchanged on both or neither
  - never wraps: range 0..DEPTH
- Flush (clk edge with flush=1, rst=1):
  - Next cycle all v <= 0 and count <= 0.
  - The input is not accepted.
  - An output transfer in the flush cycle still completes from the downstream view, since out_valid was 1; that entry is discarded internally.
- Reset (rst==0 on edge): all v <= 0 and count <= 0, overriding flush and any handshake. Reset mid-stream drops every entry.
- Reset values: out_valid=0, count=0, in_ready=out_ready|~v (evaluates to 1 after reset). out_data per Optional Feature.
- No X on out_valid or count after the first reset edge.

Optional Feature:
SM_PIPE_REG_DATA_RESET_EN
- Defined: every d[i] is cleared to 0 on reset and on flush, so out_data==0 after reset/flush until new data arrives.
- Undefined: d[i] has no reset and no flush clear. Only valid bits and count reset. This saves area; out_data is unspecified while out_valid==0.
- Handshake and count behaviour are identical in both builds.

Decomposition:
- Package sm_pipe_pkg holds only the helper function for CNT_W (clog2 of DEPTH+1). There are no typedefs; width stays a parameter.
- One sub-module, sm_pipe_stage (WIDTH):
  - inputs: clk, rst, flush, load, vin, din
  - outputs: vout, dout
- The top level instantiates DEPTH stages in a generate loop and builds the ready chain and count.

Test Plan:
- Reset: DEPTH=2, rst=0 for 2 cycles with in_valid=1 -> out_valid=0, count=0, in_ready=1 after release; with the feature defined, out_data=32'h0.
- Streaming: DEPTH=3, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_valid first high 3 cycles after 0x11 accepted, outputs 0x11,0x22,0x33 back-to-back, count peaks at 3.
- Back-pressure fill: DEPTH=2, out_ready=0, push 0xA,0xB,0xC -> 0xA,0xB accepted, in_ready=0 while 0xC offered, count=2. Raise out_ready -> 0xA, 0xB, 0xC delivered in order, no loss or duplication.
- Full pass-through: DEPTH=2 full, in_valid=1, out_ready=1 for 4 cycles -> one transfer each side per cycle, count stays 2.
- Bubble collapse: DEPTH=3, out_ready=0, single entry 0x5 -> reaches stage 2 after 3 cycles; in_ready remains 1 until count=3.
- Flush and reset priority: DEPTH=4 with count=3, assert flush and in_valid=1 -> next cycle count=0, out_valid=0, input not accepted. Flush=1 with rst=0 -> reset result identical.
